// File: rtl/pwr_switch_emu_pkg.sv
// Shared types and constants for the power-switch emulator.
package pwr_switch_emu_pkg;

    // Per-domain switch state
    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } pwr_sw_state_e;

    // Latency of the legacy fixed 16-stage delay line (15 -> 16 cycles)
    localparam int DEFAULT_SWITCH_LAT = 15;

endpackage

// File: rtl/pwr_switch_emu_chan.sv
// One emulated power domain: state machine, latency down-counter and
// registered ack / busy / abort outputs.
module pwr_switch_emu_chan
    import pwr_switch_emu_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter bit RESET_ON = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             switch_n_i,
    input  logic             hold_i,
    input  logic [CNT_W-1:0] lat_on_i,
    input  logic [CNT_W-1:0] lat_off_i,
    output logic             switch_ack_n_o,
    output logic             busy_o,
    output logic             abort_o
);

    localparam pwr_sw_state_e RST_STATE = RESET_ON ? ON : OFF;

    pwr_sw_state_e    r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_ack_n, w_ack_n;
    logic             r_abort, w_abort;
    logic             r_busy,  w_busy;

    // Next-state logic; hold freezes everything and suppresses abort
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ack_n = r_ack_n;
        w_abort = 1'b0;
        if (!hold_i) begin
            unique case (r_state)
                OFF: begin
                    if (!switch_n_i) begin
                        w_state = RAMP_UP;
                        w_cnt   = lat_on_i;
                    end
                end
                RAMP_UP: begin
                    // Reversal beats completion when both land on one edge
                    if (switch_n_i) begin
                        w_state = OFF;
                        w_abort = 1'b1;
                    end else if (r_cnt == '0) begin
                        w_state = ON;
                        w_ack_n = 1'b0;
                    end else begin
                        w_cnt = r_cnt - CNT_W'(1);
                    end
                end
                ON: begin
                    if (switch_n_i) begin
                        w_state = RAMP_DOWN;
                        w_cnt   = lat_off_i;
                    end
                end
                RAMP_DOWN: begin
                    if (!switch_n_i) begin
                        w_state = ON;
                        w_abort = 1'b1;
                    end else if (r_cnt == '0) begin
                        w_state = OFF;
                        w_ack_n = 1'b1;
                    end else begin
                        w_cnt = r_cnt - CNT_W'(1);
                    end
                end
                default: w_state = r_state;
            endcase
        end
        w_busy = (w_state == RAMP_UP) || (w_state == RAMP_DOWN);
    end

    // State and output registers; reset lands in the domain's power-up state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
            r_ack_n <= ~RESET_ON;
            r_abort <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ack_n <= w_ack_n;
            r_abort <= w_abort;
            r_busy  <= w_busy;
        end
    end

    assign switch_ack_n_o = r_ack_n;
    assign busy_o         = r_busy;
    assign abort_o        = r_abort;

endmodule

// File: rtl/pwr_switch_emu.sv
// Power-switch emulator top: one independent channel per power domain.
module pwr_switch_emu
    import pwr_switch_emu_pkg::*;
#(
    parameter int                     NUM_DOMAINS   = 3,
    parameter int                     CNT_W         = 8,
    parameter logic [NUM_DOMAINS-1:0] RESET_ON_MASK = '1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_DOMAINS-1:0]       switch_n_i,
    input  logic [NUM_DOMAINS*CNT_W-1:0] lat_on_i,
    input  logic [NUM_DOMAINS*CNT_W-1:0] lat_off_i,
    input  logic [NUM_DOMAINS-1:0]       hold_i,
    output logic [NUM_DOMAINS-1:0]       switch_ack_n_o,
    output logic [NUM_DOMAINS-1:0]       busy_o,
    output logic [NUM_DOMAINS-1:0]       abort_o
);

    logic [NUM_DOMAINS-1:0][CNT_W-1:0] w_lat_on;
    logic [NUM_DOMAINS-1:0][CNT_W-1:0] w_lat_off;

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
        assign w_lat_on[g]  = lat_on_i[g*CNT_W +: CNT_W];
        assign w_lat_off[g] = lat_off_i[g*CNT_W +: CNT_W];

        pwr_switch_emu_chan #(
            .CNT_W    (CNT_W),
            .RESET_ON (RESET_ON_MASK[g])
        ) u_chan (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .switch_n_i     (switch_n_i[g]),
            .hold_i         (hold_i[g]),
            .lat_on_i       (w_lat_on[g]),
            .lat_off_i      (w_lat_off[g]),
            .switch_ack_n_o (switch_ack_n_o[g]),
            .busy_o         (busy_o[g]),
            .abort_o        (abort_o[g])
        );
    end

endmodule

// File: tb/tb_pwr_switch_emu.sv
// Bench for pwr_switch_emu: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of each domain.
module tb_pwr_switch_emu;

    localparam int         ND   = 3;
    localparam int         CW   = 8;
    localparam logic [2:0] MASK = 3'b101;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [ND-1:0] sw, hold;
    logic [ND*CW-1:0] lat_on, lat_off;
    logic [ND-1:0] ack, busy, abort;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    pwr_switch_emu #(.NUM_DOMAINS(ND), .CNT_W(CW), .RESET_ON_MASK(MASK)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .switch_n_i     (sw),
        .lat_on_i       (lat_on),
        .lat_off_i      (lat_off),
        .hold_i         (hold),
        .switch_ack_n_o (ack),
        .busy_o         (busy),
        .abort_o        (abort)
    );

    // Reference model: a ramp is a countdown of "edges left until the ack
    // flips"; a request equal to the current ack level during a ramp aborts it.
    logic [ND-1:0] m_ack, m_ramp, m_abort;
    int            m_rem [ND];

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_ack   <= ~MASK;
            m_ramp  <= '0;
            m_abort <= '0;
            for (int i = 0; i < ND; i++) m_rem[i] <= 0;
        end else begin
            for (int i = 0; i < ND; i++) begin
                m_abort[i] <= 1'b0;
                if (!hold[i]) begin
                    if (!m_ramp[i]) begin
                        if (sw[i] != m_ack[i]) begin
                            m_ramp[i] <= 1'b1;
                            m_rem[i]  <= (sw[i] ? int'(lat_off[i*CW +: CW]) : int'(lat_on[i*CW +: CW])) + 1;
                        end
                    end else if (sw[i] == m_ack[i]) begin
                        m_ramp[i]  <= 1'b0;
                        m_abort[i] <= 1'b1;
                    end else begin
                        m_rem[i] <= m_rem[i] - 1;
                        if (m_rem[i] == 1) begin
                            m_ack[i]  <= sw[i];
                            m_ramp[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic set_lat(input int d, input int on, input int off);
        lat_on[d*CW +: CW]  = CW'(on);
        lat_off[d*CW +: CW] = CW'(off);
    endtask

    // Counts edges after the ramp-entry edge until ack of domain d flips
    // (n = -1 on timeout); also reports busy dropping early and any abort.
    task automatic run_until_toggle(input int d, output int n, output bit busy_ok, output bit ab);
        logic start;
        start   = ack[d];
        n       = -1;
        busy_ok = 1'b1;
        ab      = 1'b0;
        for (int e = 1; e <= 300; e++) begin
            @(posedge clk_i); #1;
            if (abort[d]) ab = 1'b1;
            if (ack[d] != start) begin
                n = e;
                break;
            end
            if (!busy[d]) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL reset_ack: got %b expected %b", ack, 3'b010); end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected %b", busy, 3'b000); end
        checks++; if (abort !== 3'b000) begin errors++; $display("FAIL reset_abort: got %b expected %b", abort, 3'b000); end
        @(negedge clk_i); rst_ni = 1'b1;
    endtask

    task automatic test_power_on();
        int n; bit bok, ab;
        set_lat(1, 15, 0);
        @(negedge clk_i); sw[1] = 1'b0;
        @(posedge clk_i); #1;
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL pon_busy_rise: got %b expected 1", busy[1]); end
        run_until_toggle(1, n, bok, ab);
        checks++; if (n != 16) begin errors++; $display("FAIL pon_latency: got %0d expected 16", n); end
        checks++; if (!bok || ab) begin errors++; $display("FAIL pon_busy_abort: got busy_ok=%0d abort=%0d expected 1/0", bok, ab); end
        checks++; if (busy[1] !== 1'b0 || ack[1] !== 1'b0) begin errors++; $display("FAIL pon_done: got busy=%b ack=%b expected 0/0", busy[1], ack[1]); end
    endtask

    task automatic test_zero_max();
        int n; bit bok, ab;
        set_lat(1, 255, 0);
        @(negedge clk_i); sw[1] = 1'b1;
        @(posedge clk_i);
        run_until_toggle(1, n, bok, ab);
        checks++; if (n != 1) begin errors++; $display("FAIL lat_zero: got %0d expected 1", n); end
        @(negedge clk_i); sw[1] = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i); set_lat(1, 3, 0);   // must not affect the running ramp
        run_until_toggle(1, n, bok, ab);
        checks++; if (n != 256 || !bok) begin errors++; $display("FAIL lat_max: got %0d busy_ok=%0d expected 256/1", n, bok); end
    endtask

    task automatic test_abort();
        int n; bit bok, ab;
        set_lat(1, 10, 0);
        @(negedge clk_i); sw[1] = 1'b1;
        @(posedge clk_i);
        run_until_toggle(1, n, bok, ab);
        @(negedge clk_i); sw[1] = 1'b0;
        @(posedge clk_i);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i); sw[1] = 1'b1;
        @(posedge clk_i); #1;
        checks++; if ({abort[1], ack[1], busy[1]} !== 3'b110) begin errors++; $display("FAIL abort_pulse: got abort/ack/busy=%b%b%b expected 110", abort[1], ack[1], busy[1]); end
        @(posedge clk_i); #1;
        checks++; if (abort[1] !== 1'b0) begin errors++; $display("FAIL abort_width: got %b expected 0", abort[1]); end
        @(negedge clk_i); sw[1] = 1'b0;
        @(posedge clk_i);
        run_until_toggle(1, n, bok, ab);
        checks++; if (n != 11 || ab) begin errors++; $display("FAIL abort_rerun: got %0d abort=%0d expected 11/0", n, ab); end
    endtask

    task automatic test_same_edge();
        set_lat(1, 0, 4);
        @(negedge clk_i); sw[1] = 1'b1;
        @(posedge clk_i);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i); sw[1] = 1'b0;        // sampled on the completion edge
        @(posedge clk_i); #1;
        checks++; if ({abort[1], ack[1], busy[1]} !== 3'b100) begin errors++; $display("FAIL same_edge: got abort/ack/busy=%b%b%b expected 100", abort[1], ack[1], busy[1]); end
        @(posedge clk_i); #1;
        checks++; if ({abort[1], ack[1]} !== 2'b00) begin errors++; $display("FAIL same_edge_after: got abort/ack=%b%b expected 00", abort[1], ack[1]); end
    endtask

    task automatic test_hold();
        int n; bit ab;
        n  = -1;
        ab = 1'b0;
        set_lat(1, 0, 8);
        @(negedge clk_i); sw[1] = 1'b1;
        @(posedge clk_i);
        for (int e = 1; e <= 200; e++) begin
            @(negedge clk_i);
            hold[1] = (e > 3 && e <= 23);
            sw[1]   = (e > 8 && e <= 13) ? 1'b0 : 1'b1;
            @(posedge clk_i); #1;
            if (abort[1]) ab = 1'b1;
            if (ack[1] == 1'b1) begin n = e; break; end
        end
        @(negedge clk_i); hold[1] = 1'b0;
        checks++; if (n != 29) begin errors++; $display("FAIL hold_latency: got %0d expected 29", n); end
        checks++; if (ab) begin errors++; $display("FAIL hold_abort: got 1 expected 0"); end
    endtask

    task automatic test_concurrent();
        int t [ND];
        logic [ND-1:0] start;
        set_lat(0, 2, 2); set_lat(1, 5, 5); set_lat(2, 9, 9);
        start = ack;
        for (int d = 0; d < ND; d++) t[d] = 0;
        @(negedge clk_i); sw = 3'b101;
        @(posedge clk_i);
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk_i); #1;
            for (int d = 0; d < ND; d++) if (t[d] == 0 && ack[d] != start[d]) t[d] = e;
        end
        checks++; if (t[0] != 3 || t[1] != 6 || t[2] != 10) begin errors++; $display("FAIL concurrent: got %0d %0d %0d expected 3 6 10", t[0], t[1], t[2]); end
        checks++; if (ack !== 3'b101) begin errors++; $display("FAIL concurrent_final: got %b expected 101", ack); end
    endtask

    task automatic test_reset_mid();
        int n; bit bok, ab;
        for (int d = 0; d < ND; d++) set_lat(d, 20, 20);
        @(negedge clk_i); sw = 3'b010;
        repeat (5) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL rst_mid_ack: got %b expected 010", ack); end
        checks++; if (busy !== 3'b000 || abort !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got busy=%b abort=%b expected 000/000", busy, abort); end
        sw = 3'b000;
        set_lat(1, 2, 2);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (busy !== 3'b010 || abort !== 3'b000) begin errors++; $display("FAIL rst_release_ramp: got busy=%b abort=%b expected 010/000", busy, abort); end
        run_until_toggle(1, n, bok, ab);
        checks++; if (n != 3) begin errors++; $display("FAIL rst_release_lat: got %0d expected 3", n); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_i);
            checks++; if (ack !== m_ack) begin errors++; $display("FAIL rand_ack cyc %0d: got %b expected %b", c, ack, m_ack); end
            checks++; if (busy !== m_ramp) begin errors++; $display("FAIL rand_busy cyc %0d: got %b expected %b", c, busy, m_ramp); end
            checks++; if (abort !== m_abort) begin errors++; $display("FAIL rand_abort cyc %0d: got %b expected %b", c, abort, m_abort); end
            for (int d = 0; d < ND; d++) begin
                if ($urandom_range(7) == 0) sw[d] = ~sw[d];
                hold[d] = ($urandom_range(9) == 0);
                set_lat(d, $urandom_range(6), $urandom_range(6));
            end
        end
        @(negedge clk_i); hold = '0;
    endtask

    initial begin
        sw   = 3'b010;
        hold = '0;
        for (int d = 0; d < ND; d++) set_lat(d, 15, 15);
        test_reset();
        test_power_on();
        test_zero_max();
        test_abort();
        test_same_edge();
        test_hold();
        test_concurrent();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
